seq_pattern_detector: RTL and testbench
=======================================

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits (2..16).
REQ-002 Parameter LEN_W, default 4, width of length field; SHALL satisfy 2**LEN_W > PAT_W.
REQ-003 Parameter CNT_W, default 8, match counter width.
REQ-004 Parameter RST_PAT, default 8'b0000_0100, pattern loaded at reset.
REQ-005 Parameter RST_LEN, default 3, length loaded at reset.
REQ-006 Parameter RST_OVL, default 1, overlap mode loaded at reset.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 in_valid  input  1  qualifies in_bit; bit consumed only when high.
REQ-010 in_bit  input  1  serial data bit.
REQ-011 cfg_load  input  1  one-cycle strobe; load cfg_pattern/cfg_len/cfg_overlap.
REQ-012 cfg_pattern  input  PAT_W  pattern; bit [len-1] is first-received, bit [0] last-received.
REQ-013 cfg_len  input  LEN_W  active pattern length.
REQ-014 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-015 cnt_clr  input  1  clear match_count.
REQ-016 match  output  1  registered one-cycle pulse per detected pattern.
REQ-017 match_count  output  CNT_W  saturating count of matches.
REQ-018 cfg_err  output  1  registered one-cycle pulse on rejected cfg_load.

Function
REQ-019 Block SHALL hold active config: pat_r (PAT_W), len_r (LEN_W), ovl_r (1).
REQ-020 Block SHALL keep history shift register hist (PAT_W) and fill counter fill (0..PAT_W, saturating).
REQ-021 On accepted bit: hist_next = {hist[PAT_W-2:0], in_bit}; fill_next = min(fill+1, PAT_W).
REQ-022 Hit SHALL be declared when accepted bit arrives, fill_next >= len_r, and hist_next[len_r-1:0] == pat_r[len_r-1:0].
REQ-023 match SHALL be high in the cycle after the hit edge, for exactly one cycle; latency 1 clock from accepting edge.
REQ-024 Overlap mode, on hit: hist and fill update normally (suffix reusable).
REQ-025 Non-overlap mode, on hit: fill SHALL be set to 0 (next match needs len_r fresh bits).
REQ-026 in_valid low: hist, fill unchanged; match low next cycle.
REQ-027 cfg_load with 1 <= cfg_len <= PAT_W: config registers updated, hist and fill cleared to 0, any in_bit that cycle dropped, no hit.
REQ-028 cfg_load with cfg_len == 0 or > PAT_W: config unchanged, history unchanged, in_bit processed normally, cfg_err pulses next cycle.
REQ-029 match_count SHALL increment by 1 per hit, saturating at 2**CNT_W-1.
REQ-030 cnt_clr and hit same cycle: match_count SHALL become 0 (clear wins); match still pulses.
REQ-031 Pattern bits above len_r-1 SHALL be ignored.
REQ-032 Change of ovl_r via valid cfg_load takes effect on the first bit after the load.

Reset
REQ-033 rst high at rising edge: hist=0, fill=0, match=0, match_count=0, cfg_err=0, pat_r=RST_PAT, len_r=RST_LEN, ovl_r=RST_OVL.
REQ-034 rst SHALL override cfg_load, cnt_clr and in_valid in the same cycle.
REQ-035 rst mid-sequence SHALL discard partial history; no match pulse may follow reset edge.
REQ-036 Default reset config SHALL detect serial "100" with overlap.

Verification
REQ-037 Defaults, stream 1,0,0,1,0,0 all valid -> match pulses one cycle after 3rd and 6th bits; match_count=2.
REQ-038 Load pattern 0b1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 -> match after 4th and 7th bits; overlap=0, same stream -> match after 4th only.
REQ-039 in_valid gaps: defaults, bits 1,(gap x3),0,(gap),0 -> single match one cycle after last valid bit; no pulse during gaps.
REQ-040 cfg_load with cfg_len=0 then len=9 (PAT_W=8) -> two cfg_err pulses, config still detects "100".
REQ-041 CNT_W=2, eight "100" repeats -> match_count saturates at 3; cnt_clr coincident with hit -> 0.
REQ-042 Stream 1,0 then rst, then 0 -> no match; match_count=0; subsequent 1,0,0 -> match.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, length and overlap mode.
// Emits a registered match pulse per hit and keeps a saturating match counter.
module seq_pattern_detector #(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_0100,
    parameter int               RST_LEN = 3,
    parameter bit               RST_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_ok;
    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic [PAT_W-1:0] len_mask;
    logic             hit;

    // Bit gi of the mask is set when it lies inside the active pattern window.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end

    assign cfg_ok     = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    assign hist_shift = {hist_q[PAT_W-2:0], in_bit};
    assign fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    // A valid reconfiguration swallows the bit arriving in the same cycle.
    assign hit        = in_valid && !cfg_ok && (fill_inc >= len_q)
                        && (((hist_shift ^ pat_q) & len_mask) == '0);

    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = hit;
        cfg_err_d = cfg_load && !cfg_ok;
        cnt_d     = cnt_q;

        if (cfg_ok) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            // Non-overlapping mode demands a full set of fresh bits after each hit.
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= RST_PAT;
            len_q     <= LEN_W'(RST_LEN);
            ovl_q     <= RST_OVL;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       match, cfg_err, match2, cfg_err2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_pattern_detector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_count(match_count), .cfg_err(cfg_err)
    );

    seq_pattern_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match2), .match_count(match_count2), .cfg_err(cfg_err2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus; outputs are observed 1 time unit after the edge.
    task automatic cycle(input logic v, input logic b, input logic ld, input logic clr, input logic r);
        in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr; rst = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
        $display("t=%0t v=%0b bit=%0b ld=%0b clr=%0b rst=%0b -> match=%0b cnt=%0d cnt2=%0d cfg_err=%0b",
                 $time, v, b, ld, clr, r, match, match_count, match_count2, cfg_err);
    endtask

    task automatic send(input logic b, input logic exp_m, input string tag);
        cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
        check_val(tag, {31'd0, match}, {31'd0, exp_m});
    endtask

    logic s1 [7];
    logic e1 [7];

    initial begin
        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rst_match", {31'd0, match}, 32'd0);
        check_val("rst_cnt", {24'd0, match_count}, 32'd0);
        check_val("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check_val("rst_cnt2", {30'd0, match_count2}, 32'd0);

        // Default "100" with overlap: stream 1,0,0,1,0,0
        s1 = '{1, 0, 0, 1, 0, 0, 0};
        e1 = '{0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) send(s1[i], e1[i], $sformatf("def_bit%0d", i));
        check_val("def_cnt", {24'd0, match_count}, 32'd2);
        check_val("def_cnt2", {30'd0, match_count2}, 32'd2);

        // in_valid gaps: 1,(gap x3),0,(gap),0
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("clr_cnt", {24'd0, match_count}, 32'd0);
        send(1'b1, 1'b0, "gap_b0");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("gap_idle%0d", i), {31'd0, match}, 32'd0);
        end
        send(1'b0, 1'b0, "gap_b1");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("gap_idle3", {31'd0, match}, 32'd0);
        send(1'b0, 1'b1, "gap_b2");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("gap_pulse_one_cycle", {31'd0, match}, 32'd0);
        check_val("gap_cnt", {24'd0, match_count}, 32'd1);

        // Rejected loads: len 0 (with a valid bit that must still be processed), then len 9
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, "err_b0");
        send(1'b0, 1'b0, "err_b1");
        cfg_pattern = 8'hFF; cfg_len = 4'd0; cfg_overlap = 1'b0;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("err_len0_pulse", {31'd0, cfg_err}, 32'd1);
        check_val("err_len0_bit_kept", {31'd0, match}, 32'd1);
        cfg_len = 4'd9;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("err_len9_pulse", {31'd0, cfg_err}, 32'd1);
        check_val("err_len9_nomatch", {31'd0, match}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("err_pulse_one_cycle", {31'd0, cfg_err}, 32'd0);
        send(1'b1, 1'b0, "err_s0");
        send(1'b0, 1'b0, "err_s1");
        send(1'b0, 1'b1, "err_s2");
        check_val("err_cnt", {24'd0, match_count}, 32'd2);

        // Counter saturation on the 2-bit instance, then clear coincident with a hit
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            send(1'b1, 1'b0, $sformatf("sat_r%0d_a", r));
            send(1'b0, 1'b0, $sformatf("sat_r%0d_b", r));
            send(1'b0, 1'b1, $sformatf("sat_r%0d_c", r));
        end
        check_val("sat_cnt8", {24'd0, match_count}, 32'd8);
        check_val("sat_cnt2", {30'd0, match_count2}, 32'd3);
        send(1'b1, 1'b0, "clrhit_a");
        send(1'b0, 1'b0, "clrhit_b");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("clrhit_match", {31'd0, match}, 32'd1);
        check_val("clrhit_cnt", {24'd0, match_count}, 32'd0);
        check_val("clrhit_cnt2", {30'd0, match_count2}, 32'd0);

        // Reset mid-sequence overrides a valid load, a clear and a valid bit
        send(1'b1, 1'b0, "rstm_a");
        send(1'b0, 1'b0, "rstm_b");
        send(1'b0, 1'b1, "rstm_c");
        send(1'b1, 1'b0, "rstm_d");
        send(1'b0, 1'b0, "rstm_e");
        cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("rstm_match", {31'd0, match}, 32'd0);
        check_val("rstm_cnt", {24'd0, match_count}, 32'd0);
        check_val("rstm_cfg_err", {31'd0, cfg_err}, 32'd0);
        send(1'b0, 1'b0, "rstm_after0");
        send(1'b1, 1'b0, "rstm_f");
        send(1'b0, 1'b0, "rstm_g");
        send(1'b0, 1'b1, "rstm_h");
        check_val("rstm_cnt_after", {24'd0, match_count}, 32'd1);

        // Pattern 1011, overlapping
        s1 = '{1, 0, 1, 1, 0, 1, 1};
        cfg_pattern = 8'h0B; cfg_len = 4'd4; cfg_overlap = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("ld_ovl_cfg_err", {31'd0, cfg_err}, 32'd0);
        e1 = '{0, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 7; i++) send(s1[i], e1[i], $sformatf("ovl_bit%0d", i));

        // Same pattern non-overlapping; upper pattern bits are junk and must be ignored
        cfg_pattern = 8'hFB; cfg_len = 4'd4; cfg_overlap = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e1 = '{0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 7; i++) send(s1[i], e1[i], $sformatf("novl_bit%0d", i));

        // The bit presented during an accepted load is dropped
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("drop_ld_match", {31'd0, match}, 32'd0);
        send(1'b0, 1'b0, "drop_b0");
        send(1'b1, 1'b0, "drop_b1");
        send(1'b1, 1'b0, "drop_b2");

        // Full-width pattern (len == PAT_W) is accepted
        cfg_pattern = 8'hA5; cfg_len = 4'd8; cfg_overlap = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("full_cfg_err", {31'd0, cfg_err}, 32'd0);
        s1 = '{1, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) send(s1[i], 1'b0, $sformatf("full_bit%0d", i));
        send(1'b1, 1'b1, "full_bit7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
